// File: rtl/mutex_pkg.sv
// Shared types for the parametrised mutual-exclusion system: node states,
// rule codes and the node-index width helper.
package mutex_pkg;

    typedef enum logic [1:0] {
        ST_I = 2'd0,
        ST_T = 2'd1,
        ST_C = 2'd2,
        ST_E = 2'd3
    } node_state_e;

    typedef enum logic [1:0] {
        RULE_TRY  = 2'd0,
        RULE_CRIT = 2'd1,
        RULE_EXIT = 2'd2,
        RULE_IDLE = 2'd3
    } rule_e;

    function automatic int node_w(input int node_num);
        return (node_num <= 2) ? 1 : $clog2(node_num);
    endfunction

endpackage

// File: rtl/mutex_node.sv
// One protocol node: 2-bit state register plus the guard and update for
// whichever rule is applied while this node is selected.
module mutex_node
    import mutex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  rule_e       rule_i,
    input  logic        sel_i,
    input  logic        x_i,
    output node_state_e state_o,
    output logic        guard_ok_o
);

    node_state_e state_q;
    node_state_e state_d;
    node_state_e target;
    logic        guard;

    always_comb begin
        guard  = 1'b0;
        target = state_q;
        case (rule_i)
            RULE_TRY:  begin guard = (state_q == ST_I);         target = ST_T; end
            RULE_CRIT: begin guard = (state_q == ST_T) && x_i;  target = ST_C; end
            RULE_EXIT: begin guard = (state_q == ST_C);         target = ST_E; end
            RULE_IDLE: begin guard = (state_q == ST_E);         target = ST_I; end
            default:   begin guard = 1'b0;                      target = state_q; end
        endcase
    end

    // Gating by sel_i keeps unselected nodes (and X on idle inputs) out of the state.
    assign guard_ok_o = sel_i && guard;

    always_comb begin
        state_d = state_q;
        if (guard_ok_o) begin
            state_d = target;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_I;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/mutex_system_param.sv
// NODE_NUM-node mutual-exclusion system: at most one guarded rule fires per
// cycle; the top owns the token, status strobes, entry counter and monitor.
module mutex_system_param
    import mutex_pkg::*;
#(
    parameter  int NODE_NUM = 3,
    parameter  int CNT_W    = 8,
    localparam int NODE_W   = node_w(NODE_NUM)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_en_valid,
    input  logic [1:0]            io_en_rule,
    input  logic [NODE_W-1:0]     io_en_node,
    output logic [2*NODE_NUM-1:0] io_n_state,
    output logic                  io_x,
    output logic                  io_fired,
    output logic                  io_rejected,
    output logic [CNT_W-1:0]      io_crit_count,
    output logic                  io_violation
);

    rule_e                rule;
    logic [NODE_NUM-1:0]  sel;
    logic [NODE_NUM-1:0]  guard_ok;
    logic [NODE_NUM-1:0]  in_cs;
    node_state_e          node_st [NODE_NUM];

    logic             x_q, x_d;
    logic             fired_q, rejected_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             viol_q;
    logic             fire;
    logic             bad;

    assign rule = rule_e'(io_en_rule);

    generate
        for (genvar gi = 0; gi < NODE_NUM; gi++) begin : g_node
            assign sel[gi] = io_en_valid && (io_en_node == NODE_W'(gi));

            mutex_node u_node (
                .clk_i      (clock),
                .rst_i      (reset),
                .rule_i     (rule),
                .sel_i      (sel[gi]),
                .x_i        (x_q),
                .state_o    (node_st[gi]),
                .guard_ok_o (guard_ok[gi])
            );

            assign io_n_state[2*gi +: 2] = node_st[gi];
            assign in_cs[gi] = (node_st[gi] == ST_C) || (node_st[gi] == ST_E);
        end
    endgenerate

    // Out-of-range indices select no node, so they fall out as a false guard.
    assign fire = |guard_ok;

    always_comb begin
        x_d   = x_q;
        cnt_d = cnt_q;
        if (fire && (rule == RULE_CRIT)) begin
            x_d = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (fire && (rule == RULE_IDLE)) begin
            x_d = 1'b1;
        end
    end

    // More than one bit set in in_cs, or a critical node while the token is free.
    assign bad = ((in_cs & (in_cs - 1'b1)) != '0) || ((|in_cs) && x_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q        <= 1'b1;
            fired_q    <= 1'b0;
            rejected_q <= 1'b0;
            cnt_q      <= '0;
            viol_q     <= 1'b0;
        end else begin
            x_q        <= x_d;
            fired_q    <= io_en_valid && fire;
            rejected_q <= io_en_valid && !fire;
            cnt_q      <= cnt_d;
            viol_q     <= viol_q || bad;
        end
    end

    assign io_x          = x_q;
    assign io_fired      = fired_q;
    assign io_rejected   = rejected_q;
    assign io_crit_count = cnt_q;
    assign io_violation  = viol_q;

endmodule

// File: tb/tb_mutex_system_param.sv
// Directed bench: a 3-node instance driven from a vector table, plus a
// 4-node instance with a 2-bit counter for saturation, and async reset checks.
module tb_mutex_system_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: NODE_NUM=3, CNT_W=8
    logic       a_valid = 1'b0;
    logic [1:0] a_rule  = 2'd0;
    logic [1:0] a_node  = 2'd0;
    logic [5:0] a_state;
    logic       a_x, a_fired, a_rej, a_viol;
    logic [7:0] a_cnt;

    mutex_system_param #(.NODE_NUM(3), .CNT_W(8)) u_a (
        .clock         (clk),
        .reset         (rst),
        .io_en_valid   (a_valid),
        .io_en_rule    (a_rule),
        .io_en_node    (a_node),
        .io_n_state    (a_state),
        .io_x          (a_x),
        .io_fired      (a_fired),
        .io_rejected   (a_rej),
        .io_crit_count (a_cnt),
        .io_violation  (a_viol)
    );

    // Instance B: NODE_NUM=4, CNT_W=2
    logic       b_valid = 1'b0;
    logic [1:0] b_rule  = 2'd0;
    logic [1:0] b_node  = 2'd0;
    logic [7:0] b_state;
    logic       b_x, b_fired, b_rej, b_viol;
    logic [1:0] b_cnt;

    mutex_system_param #(.NODE_NUM(4), .CNT_W(2)) u_b (
        .clock         (clk),
        .reset         (rst),
        .io_en_valid   (b_valid),
        .io_en_rule    (b_rule),
        .io_en_node    (b_node),
        .io_n_state    (b_state),
        .io_x          (b_x),
        .io_fired      (b_fired),
        .io_rejected   (b_rej),
        .io_crit_count (b_cnt),
        .io_violation  (b_viol)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       valid;
        logic [1:0] rule;
        logic [1:0] node;
        logic [5:0] st;
        logic       x;
        logic       fired;
        logic       rej;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs [15];

    task automatic check_a(input string tag, input logic [5:0] st, input logic x,
                           input logic f, input logic r, input logic [7:0] cnt);
        chk({tag, " state"},     32'(a_state), 32'(st));
        chk({tag, " x"},         32'(a_x),     32'(x));
        chk({tag, " fired"},     32'(a_fired), 32'(f));
        chk({tag, " rejected"},  32'(a_rej),   32'(r));
        chk({tag, " count"},     32'(a_cnt),   32'(cnt));
        chk({tag, " violation"}, 32'(a_viol),  32'd0);
    endtask

    task automatic step_b(input logic [1:0] rule, input logic [1:0] node);
        @(negedge clk);
        b_valid = 1'b1; b_rule = rule; b_node = node;
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    initial begin
        // rule codes: 0 Try, 1 Crit, 2 Exit, 3 Idle; states I=0 T=1 C=2 E=3
        vecs[0]  = '{1'b1, 2'd0, 2'd0, 6'h01, 1'b1, 1'b1, 1'b0, 8'd0}; // Try n0
        vecs[1]  = '{1'b1, 2'd1, 2'd0, 6'h02, 1'b0, 1'b1, 1'b0, 8'd1}; // Crit n0
        vecs[2]  = '{1'b1, 2'd0, 2'd1, 6'h06, 1'b0, 1'b1, 1'b0, 8'd1}; // Try n1
        vecs[3]  = '{1'b1, 2'd1, 2'd1, 6'h06, 1'b0, 1'b0, 1'b1, 8'd1}; // Crit n1 blocked
        vecs[4]  = '{1'b1, 2'd2, 2'd0, 6'h07, 1'b0, 1'b1, 1'b0, 8'd1}; // Exit n0
        vecs[5]  = '{1'b1, 2'd3, 2'd0, 6'h04, 1'b1, 1'b1, 1'b0, 8'd1}; // Idle n0
        vecs[6]  = '{1'b1, 2'd1, 2'd1, 6'h08, 1'b0, 1'b1, 1'b0, 8'd2}; // Crit n1
        vecs[7]  = '{1'b1, 2'd0, 2'd3, 6'h08, 1'b0, 1'b0, 1'b1, 8'd2}; // Try n3 out of range
        vecs[8]  = '{1'b0, 2'd2, 2'd1, 6'h08, 1'b0, 1'b0, 1'b0, 8'd2}; // idle cycle
        vecs[9]  = '{1'b1, 2'd3, 2'd1, 6'h08, 1'b0, 1'b0, 1'b1, 8'd2}; // Idle n1 from C: blocked
        vecs[10] = '{1'b1, 2'd2, 2'd1, 6'h0C, 1'b0, 1'b1, 1'b0, 8'd2}; // Exit n1
        vecs[11] = '{1'b1, 2'd3, 2'd1, 6'h00, 1'b1, 1'b1, 1'b0, 8'd2}; // Idle n1
        vecs[12] = '{1'b1, 2'd0, 2'd2, 6'h10, 1'b1, 1'b1, 1'b0, 8'd2}; // Try n2
        vecs[13] = '{1'b1, 2'd2, 2'd2, 6'h10, 1'b1, 1'b0, 1'b1, 8'd2}; // Exit n2 from T: blocked
        vecs[14] = '{1'b1, 2'd1, 2'd2, 6'h20, 1'b0, 1'b1, 1'b0, 8'd3}; // Crit n2

        // Reset, release, then three idle cycles
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_a("reset A", 6'h00, 1'b1, 1'b0, 1'b0, 8'd0);
        chk("reset B state", 32'(b_state), 32'd0);
        chk("reset B x",     32'(b_x),     32'd1);
        chk("reset B count", 32'(b_cnt),   32'd0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            a_valid = vecs[i].valid; a_rule = vecs[i].rule; a_node = vecs[i].node;
            @(posedge clk); #1;
            $display("vec %0d: valid=%0d rule=%0d node=%0d -> state=0x%0h x=%0d fired=%0d rej=%0d cnt=%0d",
                     i, vecs[i].valid, vecs[i].rule, vecs[i].node, a_state, a_x, a_fired, a_rej, a_cnt);
            check_a($sformatf("vec%0d", i), vecs[i].st, vecs[i].x, vecs[i].fired, vecs[i].rej, vecs[i].cnt);
        end
        a_valid = 1'b0;

        // Counter saturation on the 2-bit instance, rotating over the nodes
        for (int k = 0; k < 5; k++) begin
            logic [1:0] nd;
            nd = 2'(k % 4);
            step_b(2'd0, nd); chk($sformatf("sat%0d try fired", k), 32'(b_fired), 32'd1);
            step_b(2'd1, nd); chk($sformatf("sat%0d crit fired", k), 32'(b_fired), 32'd1);
            chk($sformatf("sat%0d count", k), 32'(b_cnt), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
            step_b(2'd2, nd); chk($sformatf("sat%0d exit fired", k), 32'(b_fired), 32'd1);
            step_b(2'd3, nd); chk($sformatf("sat%0d idle x", k), 32'(b_x), 32'd1);
            chk($sformatf("sat%0d violation", k), 32'(b_viol), 32'd0);
            $display("sat round %0d node %0d: count=%0d state=0x%0h", k, nd, b_cnt, b_state);
        end

        // A: node2 is C, x=0 now. Reset asynchronously, away from any clock edge.
        @(negedge clk); #2;
        chk("pre-reset n2 in C", 32'(a_state), 32'h20);
        rst = 1'b1;
        #1;
        $display("async reset: state=0x%0h x=%0d cnt=%0d", a_state, a_x, a_cnt);
        check_a("async reset", 6'h00, 1'b1, 1'b0, 1'b0, 8'd0);
        chk("async reset B count", 32'(b_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // First request after release behaves as from power-up
        @(negedge clk);
        a_valid = 1'b1; a_rule = 2'd0; a_node = 2'd2;
        @(posedge clk); #1;
        a_valid = 1'b0;
        $display("post-reset try n2: state=0x%0h fired=%0d", a_state, a_fired);
        check_a("post-reset try", 6'h10, 1'b1, 1'b1, 1'b0, 8'd0);
        @(negedge clk);
        a_valid = 1'b1; a_rule = 2'd1; a_node = 2'd2;
        @(posedge clk); #1;
        a_valid = 1'b0;
        $display("post-reset crit n2: state=0x%0h cnt=%0d", a_state, a_cnt);
        check_a("post-reset crit", 6'h20, 1'b0, 1'b1, 1'b0, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
